// File: rtl/i2s_adc_rx_pkg.sv
// Shared audio types for the I2S capture front end: channel tags, FSM states
// and the {ch, data} word that travels through the sample FIFO.
package aud_pkg;
    localparam int AUD_DATA_W = 16;

    typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} channel_e;

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH, HOLD} i2s_state_e;

    typedef struct packed {
        channel_e                ch;
        logic [AUD_DATA_W-1:0]   data;
    } aud_word_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/i2s_adc_rx_if.sv
// Valid/ready PCM stream from the I2S receiver to the downstream analysis stages.
interface i2s_adc_rx_if
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W
);
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_ch;
    logic              i_ready;

    modport master (output o_valid, output o_data, output o_ch, input i_ready);
    modport slave  (input o_valid, input o_data, input o_ch, output i_ready);
endinterface

// File: rtl/i2s_adc_rx_sample_fifo.sv
// Show-ahead FIFO: the head entry is visible combinationally; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en   = i_pop && !o_empty;
    assign wr_en   = i_push && (!o_full || rd_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (i_flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
            if (rd_en) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= i_wdata;
    end

    // Empty FIFO presents zeros so the stream outputs are clean out of reset.
    assign o_rdata = o_empty ? '0 : mem_q[rptr_q[AW-1:0]];
endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: synchronizes BCLK/LRCK/ADCDAT, deserializes one PCM word
// per LRCK half-period and queues selected channels on a valid/ready stream.
module i2s_adc_rx
    import aud_pkg::*;
#(
    parameter int DATA_W     = AUD_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_SEL     = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_AUD_BCLK,
    input  logic                i_AUD_ADCLRCK,
    input  logic                i_AUD_ADCDAT,
    input  logic                i_clr_ovf,
    i2s_adc_rx_if.master        m_if,
    output logic                o_overflow,
    output logic [7:0]          o_err_cnt
);
    localparam int BW = $clog2(DATA_W + 1);

    logic [2:0]        bclk_sync_q;
    logic [1:0]        lr_sync_q;
    logic [1:0]        dat_sync_q;
    logic              lr_prev_q;
    logic              lr_seen_q;
    logic              bclk_rise;
    logic              lr;
    logic              dat;
    logic              boundary;

    i2s_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    channel_e          ch_q, ch_d;
    logic [7:0]        err_q, err_d;
    logic              ovf_q, ovf_d;

    logic              push_req;
    logic              push;
    logic              pop;
    logic              ch_match;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_rdata;

    assign bclk_rise = bclk_sync_q[1] && !bclk_sync_q[2];
    assign lr        = lr_sync_q[1];
    assign dat       = dat_sync_q[1];
    // lr_prev is meaningless until one BCLK edge has been seen after reset.
    assign boundary  = bclk_rise && lr_seen_q && (lr != lr_prev_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            dat_sync_q  <= '0;
            lr_prev_q   <= 1'b0;
            lr_seen_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], i_AUD_BCLK};
            lr_sync_q   <= {lr_sync_q[0], i_AUD_ADCLRCK};
            dat_sync_q  <= {dat_sync_q[0], i_AUD_ADCDAT};
            if (bclk_rise) begin
                lr_prev_q <= lr;
                lr_seen_q <= 1'b1;
            end
        end
    end

    assign ch_match = (CH_SEL == 2) || ((CH_SEL == 1) == (ch_q == CH_R));

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        ch_d     = ch_q;
        err_d    = err_q;
        push_req = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (boundary) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    ch_d     = channel_e'(lr);
                end
            end
            SHIFT: begin
                if (boundary) begin
                    // Short word: drop it and start over on the new channel.
                    err_d    = sat_inc8(err_q);
                    bitcnt_d = '0;
                    ch_d     = channel_e'(lr);
                end else if (bclk_rise) begin
                    shreg_d  = {shreg_q[DATA_W-2:0], dat};
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q == BW'(DATA_W - 1)) state_d = PUSH;
                end
            end
            PUSH: begin
                push_req = ch_match;
                state_d  = HOLD;
            end
            default: state_d = IDLE;
        endcase
        if (!i_en) state_d = IDLE;
    end

    assign push = push_req && i_en;
    assign pop  = m_if.o_valid && m_if.i_ready;

    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        else if (i_clr_ovf)             ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            ch_q     <= CH_L;
            err_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            ch_q     <= ch_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    sample_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (!i_en),
        .i_push  (push),
        .i_wdata ({ch_q, shreg_q}),
        .i_pop   (pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign m_if.o_valid = !fifo_empty;
    assign m_if.o_ch    = fifo_rdata[DATA_W];
    assign m_if.o_data  = fifo_rdata[DATA_W-1:0];
    assign o_overflow   = ovf_q;
    assign o_err_cnt    = err_q;
endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: I2S frames driven at BCLK = clk/4, expected
// words queued per DUT and checked as the stream outputs are popped.
module tb_i2s_adc_rx;
    import aud_pkg::*;

    typedef struct {
        aud_word_t w;
        bit        chk;
        longint    due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       en_l = 1'b0;
    logic       bclk = 1'b0;
    logic       lrck = 1'b1;
    logic       dat = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       ovf, ovf_l;
    logic [7:0] err, err_l;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    longint rise_cyc = 0;
    exp_t   q[$];
    exp_t   q_l[$];

    i2s_adc_rx_if #(.DATA_W(16)) s ();
    i2s_adc_rx_if #(.DATA_W(16)) s_l ();

    i2s_adc_rx #(.DATA_W(16), .FIFO_DEPTH(4), .CH_SEL(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
        .i_clr_ovf(clr_ovf), .m_if(s), .o_overflow(ovf), .o_err_cnt(err)
    );

    i2s_adc_rx #(.DATA_W(16), .FIFO_DEPTH(4), .CH_SEL(0)) dut_l (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_l),
        .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
        .i_clr_ovf(clr_ovf), .m_if(s_l), .o_overflow(ovf_l), .o_err_cnt(err_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (s.o_valid && s.i_ready) begin
            $display("[%0d] main pop ch=%0d data=%h", cyc, s.o_ch, s.o_data);
            chk("main_pop_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("main_word", {15'd0, s.o_ch, s.o_data}, {15'd0, e.w});
                if (e.chk) chk("main_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : mon_left
        exp_t e;
        if (s_l.o_valid && s_l.i_ready) begin
            $display("[%0d] left-only pop ch=%0d data=%h", cyc, s_l.o_ch, s_l.o_data);
            chk("left_pop_expected", 32'(q_l.size() != 0), 1);
            if (q_l.size() != 0) begin
                e = q_l.pop_front();
                chk("left_word", {15'd0, s_l.o_ch, s_l.o_data}, {15'd0, e.w});
            end
        end
    end

    // One I2S bit: data/LRCK change with BCLK low, BCLK rises two clocks later.
    task automatic send_bit(input logic lr, input logic d);
        bclk = 1'b0; lrck = lr; dat = d;
        repeat (2) @(negedge clk);
        bclk = 1'b1; rise_cyc = cyc;
        repeat (2) @(negedge clk);
    endtask

    // Delay slot, nbits MSB-first data bits, then two padding bits.
    task automatic send_frame(input logic lr, input logic [15:0] w, input int nbits,
                              input bit exp_main, input bit exp_l, input bit lat);
        exp_t e;
        send_bit(lr, 1'b1);
        for (int i = 0; i < nbits; i++) send_bit(lr, w[15-i]);
        e.w.ch   = channel_e'(lr);
        e.w.data = w;
        e.chk    = lat;
        e.due    = rise_cyc + 4;
        if (exp_main) q.push_back(e);
        e.chk = 1'b0;
        if (exp_l) q_l.push_back(e);
        repeat (2) send_bit(lr, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q_l.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(q.size() + q_l.size()), 0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        s.i_ready = 1'b1;
        s_l.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, s.o_valid}, 0);
        chk("rst_data", {16'd0, s.o_data}, 0);
        chk("rst_ch", {31'd0, s.o_ch}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_err", {24'd0, err}, 0);
        rst_n = 1'b1;
        en = 1'b1;

        // Partial right word right after reset must not be emitted.
        repeat (5) send_bit(1'b1, 1'b1);
        send_frame(1'b0, 16'h8001, 16, 1, 0, 1);
        send_frame(1'b1, 16'h7FFE, 16, 1, 0, 1);
        drain();

        // LRCK toggles after 10 data bits (+2 pad): short word.
        send_frame(1'b0, 16'hFFFF, 10, 0, 0, 0);
        send_frame(1'b1, 16'h1234, 16, 1, 0, 0);
        drain();
        chk("err_after_short", {24'd0, err}, 1);

        // Stall downstream for five words: the fifth is dropped.
        s.i_ready = 1'b0;
        send_frame(1'b0, 16'h1111, 16, 1, 0, 0);
        send_frame(1'b1, 16'h2222, 16, 1, 0, 0);
        send_frame(1'b0, 16'h3333, 16, 1, 0, 0);
        send_frame(1'b1, 16'h4444, 16, 1, 0, 0);
        send_frame(1'b0, 16'h5555, 16, 0, 0, 0);
        chk("ovf_set", {31'd0, ovf}, 1);
        chk("stall_head", {16'd0, s.o_data}, 32'h1111);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", {31'd0, ovf}, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 0);
        s.i_ready = 1'b1;
        drain();

        // Drop enable with three words buffered.
        s.i_ready = 1'b0;
        send_frame(1'b1, 16'h0A0A, 16, 0, 0, 0);
        send_frame(1'b0, 16'h0B0B, 16, 0, 0, 0);
        send_frame(1'b1, 16'h0C0C, 16, 0, 0, 0);
        chk("valid_buffered", {31'd0, s.o_valid}, 1);
        en = 1'b0;
        @(negedge clk);
        chk("valid_flushed", {31'd0, s.o_valid}, 0);
        chk("err_kept", {24'd0, err}, 1);
        en = 1'b1;
        s.i_ready = 1'b1;
        send_frame(1'b1, 16'hEEEE, 16, 0, 0, 0);
        send_frame(1'b0, 16'hDDDD, 16, 1, 0, 0);
        drain();

        // Left-only instance sees the same alternating frames.
        en_l = 1'b1;
        send_frame(1'b1, 16'h5A5A, 16, 1, 0, 0);
        send_frame(1'b0, 16'hA5A5, 16, 1, 1, 0);
        send_frame(1'b1, 16'h5A5A, 16, 1, 0, 0);
        send_frame(1'b0, 16'hA5A5, 16, 1, 1, 0);
        drain();

        // Reset in the middle of a right word.
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_valid", {31'd0, s.o_valid}, 0);
        chk("midrst_err", {24'd0, err}, 0);
        chk("midrst_err_l", {24'd0, err_l}, 0);
        rst_n = 1'b1;
        repeat (9) send_bit(1'b1, 1'b1);
        send_frame(1'b0, 16'hF00F, 16, 1, 1, 0);
        send_frame(1'b1, 16'h0FF0, 16, 1, 0, 0);
        drain();
        chk("end_ovf_l", {31'd0, ovf_l}, 0);
        chk("end_ovf", {31'd0, ovf}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
